// File: rtl/if_fetch_redirect_pkg.sv
// if_fetch_redirect_pkg: shared widths, exception code, fetch FSM states and
// the ID-bound bus packing helper for the instruction-fetch stage.
package if_fetch_redirect_pkg;

   localparam int BR_BUS_WD         = 34;
   localparam int FS_TO_DS_BUS_WD   = 70;
   localparam int CP0_OUT_BUS_WIDTH = 35;
   localparam int FS_BUF_WD         = 64;

   localparam logic [4:0] EXCODE_ADEL = 5'h04;

   // cp0_out_bus layout: [34:33] ignored status bits, [32] flush_and_jump, [31:0] target
   localparam int CP0_FLUSH_BIT = 32;
   // br_bus layout: [33] br_stall, [32] br_taken, [31:0] br_target
   localparam int BR_STALL_BIT  = 33;
   localparam int BR_TAKEN_BIT  = 32;

   typedef enum logic [2:0] {
      FS_IDLE   = 3'd0,
      FS_REQ    = 3'd1,
      FS_WAIT   = 3'd2,
      FS_CANCEL = 3'd3,
      FS_HALT   = 3'd4
   } fs_state_e;

   // Build {fs_ex, fs_excode, fs_inst, fs_pc} for the ID stage.
   function automatic logic [FS_TO_DS_BUS_WD-1:0] fs_pack(
      input logic        ex,
      input logic [4:0]  excode,
      input logic [31:0] inst,
      input logic [31:0] pc
   );
      return {ex, excode, inst, pc};
   endfunction

endpackage

// File: rtl/if_fetch_redirect_fs_inst_buf.sv
// if_fetch_redirect_fs_inst_buf: one-entry holding register for an instruction
// that returned while ID could not accept it. Clear has priority over load.
module if_fetch_redirect_fs_inst_buf
   import if_fetch_redirect_pkg::*;
#(
   parameter int W = FS_BUF_WD
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic         i_drain,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Hold one entry: flush clears it, a late return fills it, ID acceptance empties it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clr) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/if_fetch_redirect.sv
// if_fetch_redirect: fetch stage. Owns the PC, issues one outstanding SRAM-like
// instruction request at a time, delivers {ex,excode,inst,pc} to ID, and
// cancels in-flight fetches on a CP0 flush so nothing stale reaches ID.
// Optional feature macro: FETCH_ADEL_EN (misaligned PC raises AdEL instead of fetching).
module if_fetch_redirect
   import if_fetch_redirect_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [CP0_OUT_BUS_WIDTH-1:0] cp0_out_bus,
   input  logic [BR_BUS_WD-1:0]         br_bus,
   input  logic                         ds_allowin,
   output logic                         fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0]   fs_to_ds_bus,
   output logic                         inst_sram_req,
   output logic                         inst_sram_wr,
   output logic [1:0]                   inst_sram_size,
   output logic [31:0]                  inst_sram_addr,
   input  logic                         inst_sram_addr_ok,
   input  logic                         inst_sram_data_ok,
   input  logic [31:0]                  inst_sram_rdata
);

   fs_state_e                  r_state;
   logic [31:0]                r_pc;
   logic                       r_req;
   logic [31:0]                r_addr;
   logic                       r_cancel;
   logic                       r_fs_valid;
   logic [FS_TO_DS_BUS_WD-1:0] r_fs_bus;
   logic                       r_br_valid;
   logic [31:0]                r_br_tgt;

   logic                 w_flush;
   logic [31:0]          w_flush_tgt;
   logic                 w_br_taken;
   logic                 w_br_stall;
   logic [31:0]          w_br_tgt;
   logic                 w_br_live;
   logic [31:0]          w_next_pc;
   logic [31:0]          w_issue_addr;
   logic                 w_misalign;
   logic                 w_buf_valid;
   logic [FS_BUF_WD-1:0] w_buf_data;
   logic                 w_drain;
   logic                 w_slot_free;
   logic                 w_issue_idle;
   logic                 w_adel_fire;
   logic                 w_data_hit;
   logic                 w_issue_wait;
   logic                 w_issue;
   logic                 w_buf_load;
   logic                 w_unused_cp0;

   // Only flush_and_jump and the target are consumed; exception status bits are ignored.
   assign w_flush      = cp0_out_bus[CP0_FLUSH_BIT];
   assign w_flush_tgt  = cp0_out_bus[31:0];
   assign w_unused_cp0 = ^cp0_out_bus[CP0_OUT_BUS_WIDTH-1:CP0_FLUSH_BIT+1];

   assign w_br_taken = br_bus[BR_TAKEN_BIT];
   assign w_br_stall = br_bus[BR_STALL_BIT];
   assign w_br_tgt   = br_bus[31:0];
   assign w_br_live  = w_br_taken && !w_br_stall;

   // Newest redirect wins: a live resolved branch, then the buffered one, then sequential PC.
   assign w_next_pc = w_br_live  ? w_br_tgt :
                      r_br_valid ? r_br_tgt : r_pc;

`ifdef FETCH_ADEL_EN
   assign w_misalign   = |w_next_pc[1:0];
   assign w_issue_addr = w_next_pc;
`else
   logic w_unused_pc_lo;
   assign w_misalign     = 1'b0;
   assign w_issue_addr   = {w_next_pc[31:2], 2'b00};
   assign w_unused_pc_lo = ^w_next_pc[1:0];
`endif

   // A new request may start when the holding buffer is empty or is handed to ID this cycle.
   assign w_drain      = w_buf_valid && ds_allowin;
   assign w_slot_free  = !w_buf_valid || w_drain;
   assign w_issue_idle = (r_state == FS_IDLE) && !w_flush && w_slot_free && !w_misalign;
   assign w_adel_fire  = (r_state == FS_IDLE) && !w_flush && !w_buf_valid && ds_allowin && w_misalign;
   assign w_data_hit   = (r_state == FS_WAIT) && inst_sram_data_ok && !w_flush;
   assign w_issue_wait = w_data_hit && ds_allowin && !w_misalign;
   assign w_issue      = w_issue_idle || w_issue_wait;
   assign w_buf_load   = w_data_hit && !ds_allowin;

   if_fetch_redirect_fs_inst_buf #(
      .W (FS_BUF_WD)
   ) u_fs_inst_buf (
      .clk     (clk),
      .resetn  (resetn),
      .i_clr   (w_flush),
      .i_load  (w_buf_load),
      .i_drain (w_drain),
      .i_data  ({inst_sram_rdata, r_addr}),
      .o_valid (w_buf_valid),
      .o_data  (w_buf_data)
   );

   // Branch buffer: remember a taken branch that could not steer the address it arrived with.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_br_valid <= 1'b0;
         r_br_tgt   <= 32'd0;
      end else if (w_flush) begin
         r_br_valid <= 1'b0;
      end else if (w_issue) begin
         // The issued address has absorbed any usable target; keep only a still-stalled one.
         r_br_valid <= w_br_taken && w_br_stall;
         r_br_tgt   <= w_br_tgt;
      end else if (w_br_taken) begin
         r_br_valid <= 1'b1;
         r_br_tgt   <= w_br_tgt;
      end else begin
         r_br_valid <= r_br_valid;
      end
   end

   // Fetch FSM: request issue/hold, response routing, flush cancellation and ID delivery.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= FS_IDLE;
         r_pc       <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= 32'd0;
         r_cancel   <= 1'b0;
         r_fs_valid <= 1'b0;
         r_fs_bus   <= '0;
      end else begin
         r_fs_valid <= 1'b0;
         if (w_drain && !w_flush) begin
            r_fs_valid <= 1'b1;
            r_fs_bus   <= fs_pack(1'b0, 5'd0, w_buf_data[63:32], w_buf_data[31:0]);
         end
         case (r_state)
            FS_IDLE: begin
               if (w_flush) begin
                  r_pc <= w_flush_tgt;
               end else if (w_issue_idle) begin
                  r_state <= FS_REQ;
                  r_req   <= 1'b1;
                  r_addr  <= w_issue_addr;
               end else if (w_adel_fire) begin
                  r_state    <= FS_HALT;
                  r_fs_valid <= 1'b1;
                  r_fs_bus   <= fs_pack(1'b1, EXCODE_ADEL, 32'd0, w_next_pc);
               end else begin
                  r_state <= FS_IDLE;
               end
            end
            FS_REQ: begin
               // Request and address stay frozen until accepted, even across a flush.
               if (w_flush) begin
                  r_pc <= w_flush_tgt;
               end
               if (inst_sram_addr_ok) begin
                  r_req    <= 1'b0;
                  r_cancel <= 1'b0;
                  if (w_flush || r_cancel) begin
                     r_state <= FS_CANCEL;
                  end else begin
                     r_state <= FS_WAIT;
                     r_pc    <= r_addr + 32'd4;
                  end
               end else begin
                  r_cancel <= r_cancel || w_flush;
               end
            end
            FS_WAIT: begin
               if (w_flush) begin
                  r_pc    <= w_flush_tgt;
                  r_state <= inst_sram_data_ok ? FS_IDLE : FS_CANCEL;
               end else if (inst_sram_data_ok) begin
                  if (ds_allowin) begin
                     r_fs_valid <= 1'b1;
                     r_fs_bus   <= fs_pack(1'b0, 5'd0, inst_sram_rdata, r_addr);
                  end
                  if (w_issue_wait) begin
                     r_state <= FS_REQ;
                     r_req   <= 1'b1;
                     r_addr  <= w_issue_addr;
                  end else begin
                     r_state <= FS_IDLE;
                  end
               end else begin
                  r_state <= FS_WAIT;
               end
            end
            FS_CANCEL: begin
               // The response to the abandoned request is swallowed here.
               if (w_flush) begin
                  r_pc <= w_flush_tgt;
               end
               if (inst_sram_data_ok) begin
                  r_state <= FS_IDLE;
               end
            end
            FS_HALT: begin
               if (w_flush) begin
                  r_pc    <= w_flush_tgt;
                  r_state <= FS_IDLE;
               end
            end
            default: begin
               r_state  <= FS_IDLE;
               r_req    <= 1'b0;
               r_cancel <= 1'b0;
            end
         endcase
      end
   end

   assign fs_to_ds_valid = r_fs_valid;
   assign fs_to_ds_bus   = r_fs_bus;
   assign inst_sram_req  = r_req;
   assign inst_sram_wr   = 1'b0;
   assign inst_sram_size = 2'b10;
   assign inst_sram_addr = r_addr;

endmodule

// File: tb/tb_if_fetch_redirect.sv
// tb_if_fetch_redirect: directed self-checking bench for the fetch stage.
module tb_if_fetch_redirect;

   logic        clk = 1'b0;
   logic        resetn;
   logic [34:0] cp0_out_bus;
   logic [33:0] br_bus;
   logic        ds_allowin;
   logic        fs_to_ds_valid;
   logic [69:0] fs_to_ds_bus;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   if_fetch_redirect dut (
      .clk               (clk),
      .resetn            (resetn),
      .cp0_out_bus       (cp0_out_bus),
      .br_bus            (br_bus),
      .ds_allowin        (ds_allowin),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_to(input logic [31:0] tgt);
      cp0_out_bus = {2'b00, 1'b1, tgt};
   endtask

   // Expect a pending request for a, answer addr_ok then data_ok, check delivery and next request.
   task automatic serve(input logic [31:0] a, input logic [31:0] inst, input logic [31:0] next_a);
      chk("serve_req", 70'(inst_sram_req), 70'(1'b1));
      chk("serve_addr", 70'(inst_sram_addr), 70'(a));
      inst_sram_addr_ok = 1'b1;
      step();
      inst_sram_addr_ok = 1'b0;
      chk("serve_req_drop", 70'(inst_sram_req), 70'(1'b0));
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst;
      step();
      inst_sram_data_ok = 1'b0;
      chk("serve_valid", 70'(fs_to_ds_valid), 70'(1'b1));
      chk("serve_bus", fs_to_ds_bus, {1'b0, 5'd0, inst, a});
      chk("serve_next_req", 70'(inst_sram_req), 70'(1'b1));
      chk("serve_next_addr", 70'(inst_sram_addr), 70'(next_a));
   endtask

   // Flush while a request is held, accept it, swallow its data, return to IDLE.
   task automatic flush_in_req(input logic [31:0] tgt);
      flush_to(tgt);
      step();
      cp0_out_bus = '0;
      inst_sram_addr_ok = 1'b1;
      step();
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hdeadbeef;
      step();
      inst_sram_data_ok = 1'b0;
      chk("fir_no_valid", 70'(fs_to_ds_valid), 70'(1'b0));
   endtask

   initial begin
      resetn            = 1'b0;
      cp0_out_bus       = '0;
      br_bus            = '0;
      ds_allowin        = 1'b1;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'd0;
      step();
      step();
      chk("rst_req", 70'(inst_sram_req), 70'(1'b0));
      chk("rst_valid", 70'(fs_to_ds_valid), 70'(1'b0));
      chk("rst_bus", fs_to_ds_bus, 70'd0);
      chk("tie_wr", 70'(inst_sram_wr), 70'(1'b0));
      chk("tie_size", 70'(inst_sram_size), 70'(2'b10));

      // Sequential fetch from the reset vector.
      resetn = 1'b1;
      step();
      serve(32'hbfc00000, 32'h11111111, 32'hbfc00004);
      serve(32'hbfc00004, 32'h22222222, 32'hbfc00008);

      // ID back-pressure: instruction held, no new request, delivered once.
      inst_sram_addr_ok = 1'b1;
      step();
      inst_sram_addr_ok = 1'b0;
      ds_allowin        = 1'b0;
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'h33333333;
      step();
      inst_sram_data_ok = 1'b0;
      chk("bp_valid0", 70'(fs_to_ds_valid), 70'(1'b0));
      chk("bp_req0", 70'(inst_sram_req), 70'(1'b0));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_req_hold", 70'(inst_sram_req), 70'(1'b0));
         chk("bp_valid_hold", 70'(fs_to_ds_valid), 70'(1'b0));
      end
      ds_allowin = 1'b1;
      step();
      chk("bp_deliver_valid", 70'(fs_to_ds_valid), 70'(1'b1));
      chk("bp_deliver_bus", fs_to_ds_bus, {6'd0, 32'h33333333, 32'hbfc00008});
      chk("bp_next_req", 70'(inst_sram_req), 70'(1'b1));
      chk("bp_next_addr", 70'(inst_sram_addr), 70'(32'hbfc0000c));
      step();
      chk("bp_once", 70'(fs_to_ds_valid), 70'(1'b0));

      // Flush while waiting for data: returned instruction dropped.
      inst_sram_addr_ok = 1'b1;
      step();
      inst_sram_addr_ok = 1'b0;
      flush_to(32'hbfc00380);
      step();
      cp0_out_bus = '0;
      chk("fw_req", 70'(inst_sram_req), 70'(1'b0));
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hbadbad00;
      step();
      inst_sram_data_ok = 1'b0;
      chk("fw_dropped", 70'(fs_to_ds_valid), 70'(1'b0));
      step();
      chk("fw_no_stale", 70'(fs_to_ds_valid), 70'(1'b0));
      serve(32'hbfc00380, 32'h44444444, 32'hbfc00384);

      // Flush and data_ok in the same cycle: flush wins.
      inst_sram_addr_ok = 1'b1;
      step();
      inst_sram_addr_ok = 1'b0;
      flush_to(32'hbfc00380);
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hbadbad01;
      step();
      cp0_out_bus       = '0;
      inst_sram_data_ok = 1'b0;
      chk("fd_dropped", 70'(fs_to_ds_valid), 70'(1'b0));
      step();
      serve(32'hbfc00380, 32'h55555555, 32'hbfc00384);

      // Flush during REQ with addr_ok delayed three cycles.
      flush_to(32'hbfc00380);
      step();
      cp0_out_bus = '0;
      for (int i = 0; i < 2; i++) begin
         chk("fr_req_hold", 70'(inst_sram_req), 70'(1'b1));
         chk("fr_addr_hold", 70'(inst_sram_addr), 70'(32'hbfc00384));
         step();
      end
      chk("fr_addr_hold3", 70'(inst_sram_addr), 70'(32'hbfc00384));
      inst_sram_addr_ok = 1'b1;
      step();
      inst_sram_addr_ok = 1'b0;
      chk("fr_req_drop", 70'(inst_sram_req), 70'(1'b0));
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hbadbad02;
      step();
      inst_sram_data_ok = 1'b0;
      chk("fr_dropped", 70'(fs_to_ds_valid), 70'(1'b0));
      step();
      serve(32'hbfc00380, 32'h66666666, 32'hbfc00384);

      // Stalled taken branch while REQ held: applied to the next issued address.
      br_bus = {1'b1, 1'b1, 32'h00001000};
      step();
      br_bus = '0;
      chk("br_addr_hold", 70'(inst_sram_addr), 70'(32'hbfc00384));
      serve(32'hbfc00384, 32'h77777777, 32'h00001000);
      serve(32'h00001000, 32'h88888888, 32'h00001004);

      // PC wrap at the top of the address space.
      flush_in_req(32'hfffffffc);
      step();
      serve(32'hfffffffc, 32'h99999999, 32'h00000000);

      // Flush while a buffered instruction waits in IDLE: buffer cleared.
      inst_sram_addr_ok = 1'b1;
      step();
      inst_sram_addr_ok = 1'b0;
      ds_allowin        = 1'b0;
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'haaaaaaaa;
      step();
      inst_sram_data_ok = 1'b0;
      step();
      flush_to(32'hbfc00380);
      ds_allowin = 1'b1;
      step();
      cp0_out_bus = '0;
      chk("fi_no_valid", 70'(fs_to_ds_valid), 70'(1'b0));
      chk("fi_no_req", 70'(inst_sram_req), 70'(1'b0));
      step();
      chk("fi_buf_cleared", 70'(fs_to_ds_valid), 70'(1'b0));
      chk("fi_req", 70'(inst_sram_req), 70'(1'b1));
      chk("fi_addr", 70'(inst_sram_addr), 70'(32'hbfc00380));

      // Misaligned redirect target.
      flush_in_req(32'h00001002);
`ifdef FETCH_ADEL_EN
      step();
      chk("adel_no_req", 70'(inst_sram_req), 70'(1'b0));
      chk("adel_valid", 70'(fs_to_ds_valid), 70'(1'b1));
      chk("adel_bus", fs_to_ds_bus, {1'b1, 5'h04, 32'h00000000, 32'h00001002});
      step();
      chk("adel_stall_req", 70'(inst_sram_req), 70'(1'b0));
      chk("adel_stall_valid", 70'(fs_to_ds_valid), 70'(1'b0));
      flush_to(32'hbfc00000);
      step();
      cp0_out_bus = '0;
      step();
      serve(32'hbfc00000, 32'hcccccccc, 32'hbfc00004);
`else
      step();
      serve(32'h00001000, 32'hbbbbbbbb, 32'h00001004);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
